// File: rtl/bp_pkg.sv
// Shared types for the branch resolution path: 2-bit saturating counter
// encoding, its training function and the predictor update record.
package bp_pkg;

  localparam int unsigned BP_IDX_W = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic [BP_IDX_W-1:0] index;
    ctr_t                ctr;
  } bp_upd_t;

  // Saturating step of a 2-bit counter toward the resolved direction.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t r;
    case (c)
      CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
      default: r = taken ? CTR_ST  : CTR_WT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO for predictor training updates with full/empty flags.
// Push while full and pop while empty are ignored.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = bp_upd_t
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap naturally at power-of-2 depth) and count.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bp_resolve.sv
// Branch resolution unit: registered mispredict/redirect to IF and queued
// 2-bit counter training updates to the predictor.
// Optional feature macro: BP_STATS_EN (branch / mispredict counters).
module bp_resolve
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic [1:0]       ex_pred_ctr,
  input  logic [31:0]      ex_pred_target,
  input  logic             ex_act_taken,
  input  logic [31:0]      ex_act_target,
  output logic             ex_stall,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_index,
  output logic [1:0]       upd_ctr
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    ctr_t             ctr;
  } upd_t;

  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        accept, mis_det, enq, fifo_full, fifo_empty;
  ctr_t        new_ctr;
  upd_t        upd_in, upd_head;

  // Resolve the EX branch: accept gating, mispredict detect, counter training.
  always_comb begin
    accept        = ex_valid & ~ex_stall & ~mispredict_q;
    mis_det       = accept & ((ex_pred_taken != ex_act_taken) |
                              (ex_act_taken & (ex_pred_target != ex_act_target)));
    new_ctr       = ctr_next(ctr_t'(ex_pred_ctr), ex_act_taken);
    enq           = accept & (new_ctr != ctr_t'(ex_pred_ctr));
    upd_in.index  = ex_pc[IDX_W+1:2];
    upd_in.ctr    = new_ctr;
    mispredict_d  = mis_det;
    redirect_pc_d = redirect_pc_q;
    if (mis_det) begin
      redirect_pc_d = ex_act_taken ? ex_act_target : ex_pc + 32'd4;
    end
  end

  // Mispredict pulse and redirect target registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  bp_upd_fifo #(
    .DEPTH   (UPD_DEPTH),
    .entry_t (upd_t)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (enq),
    .din   (upd_in),
    .pop   (upd_ready),
    .dout  (upd_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ex_stall    = fifo_full;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = ~fifo_empty;
  assign upd_index   = upd_head.index;
  assign upd_ctr     = upd_head.ctr;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Wrapping event counters: accepted branches and emitted mispredict pulses.
  always_comb begin
    stat_branches_d    = stat_branches_q + (accept ? 32'd1 : 32'd0);
    stat_mispredicts_d = stat_mispredicts_q + (mispredict_q ? 32'd1 : 32'd0);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_bp_resolve.sv
// Directed bench for bp_resolve: vector table plus wrong-path, backpressure
// and mid-operation reset sequences.
module tb_bp_resolve;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [1:0]  ex_pred_ctr;
  logic [31:0] ex_pred_target;
  logic        ex_act_taken;
  logic [31:0] ex_act_target;
  logic        ex_stall;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_index;
  logic [1:0]  upd_ctr;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bp_resolve #(
    .IDX_W     (8),
    .UPD_DEPTH (4)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_ctr    (ex_pred_ctr),
    .ex_pred_target (ex_pred_target),
    .ex_act_taken   (ex_act_taken),
    .ex_act_target  (ex_act_target),
    .ex_stall       (ex_stall),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_index      (upd_index),
    .upd_ctr        (upd_ctr)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [1:0]  ctr;
    logic [31:0] ptgt;
    logic        at;
    logic [31:0] atgt;
    logic        mis;
    logic [31:0] red;
    logic        enq;
    logic [7:0]  idx;
    logic [1:0]  nctr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic pt, input logic [1:0] ctr,
                       input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_pred_taken  = pt;
    ex_pred_ctr    = ctr;
    ex_pred_target = ptgt;
    ex_act_taken   = at;
    ex_act_target  = atgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           pc            pt ctr ptgt          at atgt          mis red           enq idx    nctr
    vecs[0] = '{32'h0000_0000, 1, 3, 32'h0000_0400, 1, 32'h0000_0400, 0, 32'h0,        0, 8'h00, 2'd0};
    vecs[1] = '{32'h0000_0100, 0, 1, 32'h0000_0000, 1, 32'h0000_0200, 1, 32'h0000_0200, 1, 8'h40, 2'd2};
    vecs[2] = '{32'h0000_0104, 1, 2, 32'h0000_0300, 1, 32'h0000_0380, 1, 32'h0000_0380, 1, 8'h41, 2'd3};
    vecs[3] = '{32'hFFFF_FFFC, 1, 2, 32'h0000_0010, 0, 32'h0000_0000, 1, 32'h0000_0000, 1, 8'hFF, 2'd1};
    vecs[4] = '{32'h0000_0208, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0,        0, 8'h00, 2'd0};
    vecs[5] = '{32'h0000_020C, 0, 1, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0,        1, 8'h83, 2'd0};
    vecs[6] = '{32'h0000_03F0, 1, 2, 32'h0000_0500, 1, 32'h0000_0500, 0, 32'h0,        1, 8'hFC, 2'd3};
    vecs[7] = '{32'h0000_0010, 0, 2, 32'h0000_0123, 0, 32'h0000_0456, 0, 32'h0,        1, 8'h04, 2'd1};
    vecs[8] = '{32'h0000_0000, 1, 3, 32'h0000_0040, 0, 32'h0000_0000, 1, 32'h0000_0004, 1, 8'h00, 2'd2};

    nrst = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0; ex_pred_ctr = '0;
    ex_pred_target = '0; ex_act_taken = 1'b0; ex_act_target = '0; upd_ready = 1'b1;
    #12;
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_redirect",   redirect_pc,     32'd0);
    chk("rst_upd_valid",  32'(upd_valid),  32'd0);
    chk("rst_ex_stall",   32'(ex_stall),   32'd0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Table vectors, predictor always ready.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pc, vecs[i].pt, vecs[i].ctr, vecs[i].ptgt, vecs[i].at, vecs[i].atgt);
      step();
      ex_valid = 1'b0;
      chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].mis));
      if (vecs[i].mis) chk($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].red);
      chk($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].enq));
      if (vecs[i].enq) begin
        chk($sformatf("v%0d_upd_index", i), 32'(upd_index), 32'(vecs[i].idx));
        chk($sformatf("v%0d_upd_ctr", i),   32'(upd_ctr),   32'(vecs[i].nctr));
      end
      step();
      chk($sformatf("v%0d_pulse_end", i), 32'(mispredict), 32'd0);
      chk($sformatf("v%0d_drained", i),   32'(upd_valid),  32'd0);
    end

    // Wrong-path branch during the mispredict cycle is ignored.
    drive(32'h0000_0104, 1, 2, 32'h0000_0300, 1, 32'h0000_0380);
    step();
    chk("wp_first_pulse", 32'(mispredict), 32'd1);
    chk("wp_redirect",    redirect_pc,     32'h0000_0380);
    drive(32'h0000_0500, 0, 0, 32'h0000_0000, 1, 32'h0000_0700);
    step();
    ex_valid = 1'b0;
    chk("wp_no_second_pulse", 32'(mispredict), 32'd0);
    chk("wp_no_update",       32'(upd_valid),  32'd0);
    chk("wp_redirect_held",   redirect_pc,     32'h0000_0380);

    // Backpressure: fill the FIFO, hold the 5th branch, then drain in order.
    upd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(4 * i), 0, 1, 32'h0, 0, 32'h0);
      step();
    end
    chk("bp_full_stall", 32'(ex_stall),  32'd1);
    chk("bp_head_idx1",  32'(upd_index), 32'd1);
    drive(32'd20, 0, 1, 32'h0, 0, 32'h0);
    step();
    step();
    chk("bp_still_stall",   32'(ex_stall),  32'd1);
    chk("bp_head_stable",   32'(upd_index), 32'd1);
    chk("bp_head_ctr",      32'(upd_ctr),   32'd0);
    upd_ready = 1'b1;
    step();
    chk("bp_stall_release", 32'(ex_stall),  32'd0);
    chk("bp_head_idx2",     32'(upd_index), 32'd2);
    step();
    ex_valid = 1'b0;
    chk("bp_enqdeq_count",  32'(ex_stall),  32'd0);
    chk("bp_head_idx3",     32'(upd_index), 32'd3);
    step();
    chk("bp_head_idx4",     32'(upd_index), 32'd4);
    step();
    chk("bp_head_idx5",     32'(upd_index), 32'd5);
    chk("bp_idx5_valid",    32'(upd_valid), 32'd1);
    step();
    chk("bp_empty",         32'(upd_valid), 32'd0);

    // Mid-operation reset with 3 queued updates and a pending mispredict.
    upd_ready = 1'b0;
    drive(32'd4, 0, 1, 32'h0, 0, 32'h0);
    step();
    drive(32'd8, 0, 1, 32'h0, 0, 32'h0);
    step();
    drive(32'd12, 0, 1, 32'h0, 1, 32'h0000_0900);
    step();
    ex_valid = 1'b0;
    chk("rs_pre_valid",      32'(upd_valid),  32'd1);
    chk("rs_pre_mispredict", 32'(mispredict), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("rs_upd_valid",  32'(upd_valid),  32'd0);
    chk("rs_mispredict", 32'(mispredict), 32'd0);
    chk("rs_ex_stall",   32'(ex_stall),   32'd0);
`ifdef BP_STATS_EN
    chk("rs_stat_branches",    stat_branches,    32'd0);
    chk("rs_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    step();
    chk("rs_after_valid", 32'(upd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
